vram_arbiter: RTL and testbench

- Shares the single-port synchronous video RAM between two requesters: the display read port (pixel fetch) and the processor's load/store port.
- Sits between the processor/pixel printer and the framebuffer RAM, and runs on the 50 MHz system clock.
- Display reads have fixed priority. A starvation counter guarantees the CPU a slot; responses are routed back by a registered owner tag.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/sat_counter.sv | 38 +++
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and geometry for the video RAM arbiter.
package vram_pkg;

   localparam int unsigned ADDR_W   = 17;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned FB_DEPTH = 76800;   // 320x240 words

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_DISP,
      OWN_CPU_RD,
      OWN_CPU_WR
   } owner_t;

   typedef logic [ADDR_W-1:0] vaddr_t;
   typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side bundle of the video RAM arbiter: display read port and CPU load/store port.
// master = requesters (pixel printer + CPU), slave = arbiter.
interface vram_arbiter_if;
   import vram_pkg::*;

   logic   disp_req;
   vaddr_t disp_addr;
   logic   disp_gnt;
   logic   disp_rvalid;
   pixel_t disp_rdata;

   logic   cpu_req;
   logic   cpu_we;
   vaddr_t cpu_addr;
   pixel_t cpu_wdata;
   logic   cpu_gnt;
   logic   cpu_err;
   logic   cpu_rvalid;
   pixel_t cpu_rdata;

   modport master (
      output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  disp_gnt, disp_rvalid, disp_rdata, cpu_gnt, cpu_err, cpu_rvalid, cpu_rdata
   );

   modport slave (
      input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output disp_gnt, disp_rvalid, disp_rdata, cpu_gnt, cpu_err, cpu_rvalid, cpu_rdata
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned Width = 8,
   parameter int unsigned Limit = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [Width-1:0] count
);

   localparam logic [Width-1:0] Max = Width'(Limit);

   logic [Width-1:0] count_q, count_d;

   // Next count: clear, else step unless already at the limit.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != Max)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads have fixed priority, a starvation counter
// forces a CPU slot, and read responses are routed back by a registered owner tag.
// Optional: define VRAM_ARB_STATS_EN to enable the display-denied cycle counter.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   vram_arbiter_if.slave bus,
   output vaddr_t      ram_addr,
   output logic        ram_we,
   output pixel_t      ram_wdata,
   input  pixel_t      ram_rdata,
   output logic [15:0] disp_miss_cnt
);

   localparam vaddr_t      FbEnd     = vaddr_t'(FB_DEPTH);
   localparam int unsigned StarveW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

   logic [StarveW-1:0] starve_cnt;
   logic   cpu_in_range, cpu_oor, cpu_forced;
   logic   disp_win, cpu_win, cpu_gnt;
   owner_t owner_q, owner_d;
   logic   oor_rd_q;
   vaddr_t last_addr_q;
   pixel_t disp_rdata_q, cpu_rdata_q;
   pixel_t disp_rdata, cpu_rdata;
   logic   disp_rvalid, cpu_rvalid;

   // Grant decision; out-of-range CPU requests bypass the RAM and never block the display.
   always_comb begin
      cpu_in_range = bus.cpu_req && (bus.cpu_addr < FbEnd);
      cpu_oor      = rst && bus.cpu_req && (bus.cpu_addr >= FbEnd);
      cpu_forced   = cpu_in_range && (starve_cnt == StarveMax);
      disp_win     = rst && bus.disp_req && !cpu_forced;
      cpu_win      = rst && cpu_in_range && (cpu_forced || !bus.disp_req);
      cpu_gnt      = cpu_win || cpu_oor;
   end

   sat_counter #(
      .Width (StarveW),
      .Limit (STARVE_LIMIT)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.cpu_req && !cpu_gnt),
      .clr   (!bus.cpu_req || cpu_gnt),
      .count (starve_cnt)
   );

   // RAM port mux; address holds its last value when idle to avoid toggling.
   always_comb begin
      ram_addr  = last_addr_q;
      ram_we    = 1'b0;
      ram_wdata = bus.cpu_wdata;
      owner_d   = OWN_NONE;
      if (disp_win) begin
         ram_addr = bus.disp_addr;
         owner_d  = OWN_DISP;
      end else if (cpu_win) begin
         ram_addr = bus.cpu_addr;
         ram_we   = bus.cpu_we;
         owner_d  = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
      end
   end

   // Owner tag, out-of-range read flag, held address and held read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q      <= OWN_NONE;
         oor_rd_q     <= 1'b0;
         last_addr_q  <= '0;
         disp_rdata_q <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         oor_rd_q     <= cpu_oor && !bus.cpu_we;
         last_addr_q  <= ram_addr;
         disp_rdata_q <= disp_rdata;
         cpu_rdata_q  <= cpu_rdata;
      end
   end

   // Response routing: RAM data lands the cycle after the grant.
   always_comb begin
      disp_rvalid = (owner_q == OWN_DISP);
      cpu_rvalid  = (owner_q == OWN_CPU_RD) || oor_rd_q;
      disp_rdata  = disp_rvalid ? ram_rdata : disp_rdata_q;
      cpu_rdata   = cpu_rdata_q;
      if (owner_q == OWN_CPU_RD) begin
         cpu_rdata = ram_rdata;
      end else if (oor_rd_q) begin
         cpu_rdata = '0;
      end
   end

   assign bus.disp_gnt    = disp_win;
   assign bus.disp_rvalid = disp_rvalid;
   assign bus.disp_rdata  = disp_rdata;
   assign bus.cpu_gnt     = cpu_gnt;
   assign bus.cpu_err     = cpu_oor;
   assign bus.cpu_rvalid  = cpu_rvalid;
   assign bus.cpu_rdata   = cpu_rdata;

`ifdef VRAM_ARB_STATS_EN
   sat_counter #(
      .Width (16),
      .Limit (16'hFFFF)
   ) u_disp_miss (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.disp_req && !disp_win),
      .clr   (1'b0),
      .count (disp_miss_cnt)
   );
`else
   assign disp_miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
   import vram_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   vaddr_t      ram_addr;
   logic        ram_we;
   pixel_t      ram_wdata;
   pixel_t      ram_rdata;
   logic [15:0] disp_miss_cnt;

   logic        pl_we = 1'b0;
   vaddr_t      pl_addr = '0;
   pixel_t      pl_data = '0;
   pixel_t      mem [0:131071];

   int tests_run = 0;
   int tests_failed = 0;

   vram_arbiter_if bus ();

   vram_arbiter #(
      .STARVE_LIMIT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .ram_addr      (ram_addr),
      .ram_we        (ram_we),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata),
      .disp_miss_cnt (disp_miss_cnt)
   );

   always #10 clk = ~clk;

   // Synchronous single-port RAM with a bench-side preload path.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.disp_req = 1'b0; bus.disp_addr = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
   endtask

   task automatic preload(input vaddr_t a, input pixel_t d);
      next_cyc();
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      next_cyc();
      pl_we = 1'b0;
   endtask

   task automatic test_reset();
      bus.disp_req = 1'b1; bus.disp_addr = 17'd5;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'd9; bus.cpu_wdata = 8'h11;
      preload(17'd100, 8'hA5);
      preload(17'd7, 8'h5A);
      preload(17'd300, 8'hC3);
      sample();
      tests_run++; if (bus.disp_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_disp_gnt: got %b want 0", bus.disp_gnt); end
      tests_run++; if (bus.cpu_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu_gnt: got %b want 0", bus.cpu_gnt); end
      tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      tests_run++; if (bus.disp_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b%b want 00", bus.disp_rvalid, bus.cpu_rvalid); end
      tests_run++; if (bus.disp_rdata !== 8'h00 || bus.cpu_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h want 00/00", bus.disp_rdata, bus.cpu_rdata); end
      tests_run++; if (disp_miss_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_miss_cnt: got %h want 0000", disp_miss_cnt); end
      next_cyc();
      idle();
      rst = 1'b1;
   endtask

   task automatic test_disp_read();
      next_cyc();
      bus.disp_req = 1'b1; bus.disp_addr = 17'd100;
      sample();
      tests_run++; if (bus.disp_gnt !== 1'b1) begin tests_failed++; $display("FAIL disp_gnt: got %b want 1", bus.disp_gnt); end
      tests_run++; if (ram_addr !== 17'd100 || ram_we !== 1'b0) begin tests_failed++; $display("FAIL disp_ram: got %0d/%b want 100/0", ram_addr, ram_we); end
      next_cyc();
      bus.disp_req = 1'b0;
      sample();
      tests_run++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL disp_resp: got %b/%h want 1/a5", bus.disp_rvalid, bus.disp_rdata); end
      next_cyc();
      sample();
      tests_run++; if (bus.disp_rvalid !== 1'b0 || bus.disp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL disp_hold: got %b/%h want 0/a5", bus.disp_rvalid, bus.disp_rdata); end
      tests_run++; if (ram_addr !== 17'd100) begin tests_failed++; $display("FAIL idle_addr_hold: got %0d want 100", ram_addr); end
   endtask

   task automatic test_contention();
      next_cyc();
      bus.disp_req = 1'b1; bus.disp_addr = 17'd50;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd7;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_cyc();
         sample();
         tests_run++; if (bus.cpu_gnt !== 1'b0 || bus.disp_gnt !== 1'b1) begin tests_failed++; $display("FAIL contend_wait%0d: got cpu%b disp%b want cpu0 disp1", i, bus.cpu_gnt, bus.disp_gnt); end
      end
      next_cyc();
      sample();
      tests_run++; if (bus.cpu_gnt !== 1'b1 || bus.disp_gnt !== 1'b0) begin tests_failed++; $display("FAIL contend_force: got cpu%b disp%b want cpu1 disp0", bus.cpu_gnt, bus.disp_gnt); end
      tests_run++; if (ram_addr !== 17'd7 || bus.cpu_err !== 1'b0) begin tests_failed++; $display("FAIL contend_addr: got %0d/err%b want 7/err0", ram_addr, bus.cpu_err); end
      next_cyc();
      bus.cpu_req = 1'b0;
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h5A) begin tests_failed++; $display("FAIL contend_resp: got %b/%h want 1/5a", bus.cpu_rvalid, bus.cpu_rdata); end
      tests_run++; if (bus.disp_rvalid !== 1'b0 || bus.disp_gnt !== 1'b1) begin tests_failed++; $display("FAIL contend_disp: got rv%b gnt%b want rv0 gnt1", bus.disp_rvalid, bus.disp_gnt); end
      next_cyc();
      bus.disp_req = 1'b0;
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'h5A) begin tests_failed++; $display("FAIL contend_hold: got %b/%h want 0/5a", bus.cpu_rvalid, bus.cpu_rdata); end
   endtask

   task automatic test_write_then_read();
      next_cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'd200; bus.cpu_wdata = 8'h3C;
      sample();
      tests_run++; if (bus.cpu_gnt !== 1'b1 || ram_we !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt: got gnt%b we%b want gnt1 we1", bus.cpu_gnt, ram_we); end
      tests_run++; if (ram_addr !== 17'd200 || ram_wdata !== 8'h3C) begin tests_failed++; $display("FAIL wr_bus: got %0d/%h want 200/3c", ram_addr, ram_wdata); end
      next_cyc();
      idle();
      bus.disp_req = 1'b1; bus.disp_addr = 17'd200;
      sample();
      tests_run++; if (bus.disp_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_follow: got gnt%b crv%b want gnt1 crv0", bus.disp_gnt, bus.cpu_rvalid); end
      next_cyc();
      bus.disp_req = 1'b0;
      sample();
      tests_run++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 8'h3C) begin tests_failed++; $display("FAIL wr_readback: got %b/%h want 1/3c", bus.disp_rvalid, bus.disp_rdata); end
   endtask

   task automatic test_out_of_range();
      next_cyc();
      bus.disp_req = 1'b1; bus.disp_addr = 17'd100;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd76800;
      sample();
      tests_run++; if (bus.cpu_gnt !== 1'b1 || bus.cpu_err !== 1'b1) begin tests_failed++; $display("FAIL oor_gnt: got gnt%b err%b want gnt1 err1", bus.cpu_gnt, bus.cpu_err); end
      tests_run++; if (bus.disp_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 17'd100) begin tests_failed++; $display("FAIL oor_disp: got gnt%b we%b addr%0d want gnt1 we0 addr100", bus.disp_gnt, ram_we, ram_addr); end
      next_cyc();
      idle();
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h00) begin tests_failed++; $display("FAIL oor_resp: got %b/%h want 1/00", bus.cpu_rvalid, bus.cpu_rdata); end
      tests_run++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL oor_disp_resp: got %b/%h want 1/a5", bus.disp_rvalid, bus.disp_rdata); end
      next_cyc();
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL oor_pulse: got %b want 0", bus.cpu_rvalid); end
   endtask

   task automatic test_reset_mid();
      next_cyc();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd300;
      next_cyc();
      bus.cpu_req = 1'b0;
      sample();
      tests_run++; if (bus.cpu_rdata !== 8'hC3) begin tests_failed++; $display("FAIL rmid_pre: got %h want c3", bus.cpu_rdata); end
      next_cyc();
      bus.cpu_req = 1'b1; bus.cpu_addr = 17'd7;
      sample();
      tests_run++; if (bus.cpu_gnt !== 1'b1) begin tests_failed++; $display("FAIL rmid_gnt: got %b want 1", bus.cpu_gnt); end
      #1;
      rst = 1'b0;
      bus.cpu_req = 1'b0;
      #1;
      tests_run++; if (bus.cpu_gnt !== 1'b0 || bus.cpu_rdata !== 8'h00 || bus.disp_rdata !== 8'h00) begin tests_failed++; $display("FAIL rmid_inreset: got gnt%b %h/%h want gnt0 00/00", bus.cpu_gnt, bus.cpu_rdata, bus.disp_rdata); end
      next_cyc();
      rst = 1'b1;
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rmid_dropped: got %b want 0", bus.cpu_rvalid); end
      next_cyc();
      bus.cpu_req = 1'b1; bus.cpu_addr = 17'd7;
      sample();
      tests_run++; if (bus.cpu_gnt !== 1'b1) begin tests_failed++; $display("FAIL rmid_regnt: got %b want 1", bus.cpu_gnt); end
      next_cyc();
      bus.cpu_req = 1'b0;
      sample();
      tests_run++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h5A) begin tests_failed++; $display("FAIL rmid_read: got %b/%h want 1/5a", bus.cpu_rvalid, bus.cpu_rdata); end
   endtask

   task automatic test_stats();
      int     wins = 0;
      int     budget = 0;
      logic [15:0] exp_miss;
`ifdef VRAM_ARB_STATS_EN
      exp_miss = 16'd3;
`else
      exp_miss = 16'd0;
`endif
      next_cyc();
      rst = 1'b0;
      next_cyc();
      rst = 1'b1;
      bus.disp_req = 1'b1; bus.disp_addr = 17'd10;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd7;
      while (wins < 3 && budget < 40) begin
         sample();
         if (bus.cpu_gnt === 1'b1) wins++;
         next_cyc();
         bus.cpu_req = (wins < 3);
         budget++;
      end
      tests_run++; if (wins !== 3) begin tests_failed++; $display("FAIL stats_wins: got %0d want 3", wins); end
      sample();
      tests_run++; if (disp_miss_cnt !== exp_miss) begin tests_failed++; $display("FAIL stats_miss: got %0d want %0d", disp_miss_cnt, exp_miss); end
      next_cyc();
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_disp_read();
      test_contention();
      test_write_then_read();
      test_out_of_range();
      test_reset_mid();
      test_stats();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
